data_sram_resp: RTL and testbench

Responder end of the core's data SRAM port: a word-addressed, byte-writable synchronous data RAM that accepts the execute stage's request bundle and returns read data a fixed number of cycles later to the memory stage. It replaces the bare `$readmemh` RAM in the local simulation environment. It adds a read-valid pulse, out-of-range error reporting and access counters so that load/store behaviour can be checked cycle-accurately.

---
 rtl/data_sram_resp_pkg.sv | 9 +
 rtl/dsram_array.sv | 35 +++
 rtl/data_sram_resp.sv | 116 +++++++++++
 tb/tb_data_sram_resp.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared constants for the data SRAM responder: default base address, maximum read latency
// and write-strobe width. No timing or flow control of its own.
package data_sram_resp_pkg;

   localparam logic [31:0] DSRAM_BASE_ADDR = 32'h1c00_0000;
   localparam int unsigned DSRAM_MAX_LAT   = 4;
   localparam int unsigned DSRAM_WSTRB_W   = 4;

endpackage

// File: rtl/dsram_array.sv
// Single-port byte-enable synchronous RAM with a registered read port (1-cycle read).
// Always ready; this module applies no back-pressure.
module dsram_array
   import data_sram_resp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic                     clk,
   input  logic [DSRAM_WSTRB_W-1:0] we,
   input  logic [ADDR_WIDTH-1:0]    idx,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [2**ADDR_WIDTH];
   logic [31:0] rdata_d;
   logic [31:0] rdata_q;

   // During a write the read port returns the old word; the caller only consumes reads.
   always_comb begin
      rdata_d = mem[idx];
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DSRAM_WSTRB_W; i++) begin
         if (we[i]) begin
            mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: range check, RD_LATENCY-deep read/err pipeline, access counters.
// Latency RD_LATENCY cycles for reads and errors; always ready, writes have no response.
module data_sram_resp
   import data_sram_resp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned RD_LATENCY = 1,
   parameter logic [31:0] BASE_ADDR  = DSRAM_BASE_ADDR
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     data_sram_en,
   input  logic [DSRAM_WSTRB_W-1:0] data_sram_we,
   input  logic [31:0]              data_sram_addr,
   input  logic [31:0]              data_sram_wdata,
   output logic [31:0]              data_sram_rdata,
   output logic                     data_sram_rvalid,
   output logic                     data_sram_err,
   output logic [31:0]              rd_count,
   output logic [31:0]              wr_count
);

   logic [29:0]              woff;
   logic                     in_range;
   logic                     acc;
   logic                     rd_acc;
   logic                     wr_acc;
   logic                     oor;
   logic [ADDR_WIDTH-1:0]    idx;
   logic [DSRAM_WSTRB_W-1:0] ram_we;
   logic [31:0]              ram_rdata;
   logic [31:0]              tail_dat;
   logic                     unused_addr_lsb;

   logic [RD_LATENCY-1:0]    vld_d, vld_q;
   logic [RD_LATENCY-1:0]    err_d, err_q;
   logic [31:0]              rd_count_d, rd_count_q;
   logic [31:0]              wr_count_d, wr_count_q;

   // Range check on word offsets; a request during reset is dropped entirely.
   always_comb begin
      woff     = data_sram_addr[31:2] - BASE_ADDR[31:2];
      in_range = (woff >> ADDR_WIDTH) == '0;
      acc      = data_sram_en && !reset;
      rd_acc   = acc && in_range && (data_sram_we == '0);
      wr_acc   = acc && in_range && (data_sram_we != '0);
      oor      = acc && !in_range;
      idx      = woff[ADDR_WIDTH-1:0];
      ram_we   = wr_acc ? data_sram_we : '0;
   end

   assign unused_addr_lsb = ^data_sram_addr[1:0];

   dsram_array #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_array (
      .clk  (clk),
      .we   (ram_we),
      .idx  (idx),
      .wdata(data_sram_wdata),
      .rdata(ram_rdata)
   );

   always_comb begin
      vld_d[0] = rd_acc;
      err_d[0] = oor;
      for (int k = 1; k < RD_LATENCY; k++) begin
         vld_d[k] = vld_q[k-1];
         err_d[k] = err_q[k-1];
      end
      rd_count_d = rd_count_q + {31'd0, rd_acc};
      wr_count_d = wr_count_q + {31'd0, wr_acc};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q      <= '0;
         err_q      <= '0;
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         vld_q      <= vld_d;
         err_q      <= err_d;
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   // The RAM output register is stage 0 of the data pipeline, so only RD_LATENCY-1 extra stages.
   if (RD_LATENCY == 1) begin : g_lat1
      assign tail_dat = ram_rdata;
   end else begin : g_latn
      logic [31:0] dat_d [RD_LATENCY-1];
      logic [31:0] dat_q [RD_LATENCY-1];

      always_comb begin
         dat_d[0] = ram_rdata;
         for (int k = 1; k < RD_LATENCY - 1; k++) begin
            dat_d[k] = dat_q[k-1];
         end
      end

      always_ff @(posedge clk) begin
         dat_q <= dat_d;
      end

      assign tail_dat = dat_q[RD_LATENCY-2];
   end

   assign data_sram_rvalid = vld_q[RD_LATENCY-1];
   assign data_sram_err    = err_q[RD_LATENCY-1];
   assign data_sram_rdata  = data_sram_rvalid ? tail_dat : 32'd0;
   assign rd_count         = rd_count_q;
   assign wr_count         = wr_count_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: three instances (latency 1, 3, 4) share one request stream.
module tb_data_sram_resp;

   localparam logic [31:0] BASE = 32'h1c00_0000;

   logic        clk;
   logic        reset;
   logic        en;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic [31:0] rdata1, rdata3, rdata4;
   logic        rvalid1, rvalid3, rvalid4;
   logic        err1, err3, err4;
   logic [31:0] rdc1, rdc3, rdc4;
   logic [31:0] wrc1, wrc3, wrc4;

   int checks = 0;
   int errors = 0;

   data_sram_resp #(.ADDR_WIDTH(12), .RD_LATENCY(1), .BASE_ADDR(BASE)) u1 (
      .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_we(we),
      .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata1),
      .data_sram_rvalid(rvalid1), .data_sram_err(err1), .rd_count(rdc1), .wr_count(wrc1));

   data_sram_resp #(.ADDR_WIDTH(12), .RD_LATENCY(3), .BASE_ADDR(BASE)) u3 (
      .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_we(we),
      .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata3),
      .data_sram_rvalid(rvalid3), .data_sram_err(err3), .rd_count(rdc3), .wr_count(wrc3));

   data_sram_resp #(.ADDR_WIDTH(12), .RD_LATENCY(4), .BASE_ADDR(BASE)) u4 (
      .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_we(we),
      .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata4),
      .data_sram_rvalid(rvalid4), .data_sram_err(err4), .rd_count(rdc4), .wr_count(wrc4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rv;
      logic [31:0] rdata;
      logic        err;
      logic [31:0] rdc;
      logic [31:0] wrc;
   } vec_t;

   vec_t vecs [13];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      en    = e;
      we    = w;
      addr  = a;
      wdata = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          hit_cyc;
      logic [31:0] hit_dat;
      logic        saw;
      int          err_cyc;

      // Each row's response is visible one edge later on the latency-1 instance.
      vecs[0]  = '{1'b1, 4'hf, BASE + 32'd8,     32'hdeadbeef, 1'b0, 32'h0,        1'b0, 32'd0, 32'd1};
      vecs[1]  = '{1'b1, 4'h0, BASE + 32'd8,     32'h0,        1'b1, 32'hdeadbeef, 1'b0, 32'd1, 32'd1};
      vecs[2]  = '{1'b1, 4'hf, BASE + 32'd4,     32'h11223344, 1'b0, 32'h0,        1'b0, 32'd1, 32'd2};
      vecs[3]  = '{1'b1, 4'h5, BASE + 32'd4,     32'haabbccdd, 1'b0, 32'h0,        1'b0, 32'd1, 32'd3};
      vecs[4]  = '{1'b1, 4'h0, BASE + 32'd4,     32'h0,        1'b1, 32'h11bb33dd, 1'b0, 32'd2, 32'd3};
      vecs[5]  = '{1'b0, 4'h0, BASE + 32'd4,     32'h0,        1'b0, 32'h0,        1'b0, 32'd2, 32'd3};
      vecs[6]  = '{1'b1, 4'h0, BASE - 32'd4,     32'h0,        1'b0, 32'h0,        1'b1, 32'd2, 32'd3};
      vecs[7]  = '{1'b1, 4'hf, BASE + 32'd16384, 32'h12345678, 1'b0, 32'h0,        1'b1, 32'd2, 32'd3};
      vecs[8]  = '{1'b1, 4'h0, BASE + 32'd4,     32'h0,        1'b1, 32'h11bb33dd, 1'b0, 32'd3, 32'd3};
      vecs[9]  = '{1'b1, 4'h8, BASE + 32'd8,     32'h55000000, 1'b0, 32'h0,        1'b0, 32'd3, 32'd4};
      vecs[10] = '{1'b1, 4'h0, BASE + 32'd8,     32'h0,        1'b1, 32'h55adbeef, 1'b0, 32'd4, 32'd4};
      vecs[11] = '{1'b0, 4'hf, BASE + 32'd8,     32'h0,        1'b0, 32'h0,        1'b0, 32'd4, 32'd4};
      vecs[12] = '{1'b1, 4'h0, BASE + 32'd8,     32'h0,        1'b1, 32'h55adbeef, 1'b0, 32'd5, 32'd4};

      reset = 1'b1;
      drive(1'b0, 4'h0, BASE, 32'h0);
      step();
      step();
      chk("reset_rvalid", {31'd0, rvalid1}, 32'd0);
      chk("reset_err", {31'd0, err1}, 32'd0);
      chk("reset_rdata", rdata1, 32'd0);
      chk("reset_rd_count", rdc1, 32'd0);
      chk("reset_wr_count", wrc1, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         step();
         chk($sformatf("vec%0d_rvalid", i), {31'd0, rvalid1}, {31'd0, vecs[i].rv});
         chk($sformatf("vec%0d_rdata", i), rdata1, vecs[i].rdata);
         chk($sformatf("vec%0d_err", i), {31'd0, err1}, {31'd0, vecs[i].err});
         chk($sformatf("vec%0d_rd_count", i), rdc1, vecs[i].rdc);
         chk($sformatf("vec%0d_wr_count", i), wrc1, vecs[i].wrc);
      end
      drive(1'b0, 4'h0, BASE, 32'h0);
      for (int i = 0; i < 5; i++) step();

      // Reset two cycles after a read on the latency-4 instance, with a write riding the reset cycle.
      drive(1'b1, 4'h0, BASE + 32'd8, 32'h0);
      step();
      drive(1'b0, 4'h0, BASE, 32'h0);
      step();
      reset = 1'b1;
      drive(1'b1, 4'hf, BASE + 32'd8, 32'h0);
      step();
      reset = 1'b0;
      drive(1'b0, 4'h0, BASE, 32'h0);
      chk("flight_rd_count", rdc4, 32'd0);
      chk("flight_wr_count", wrc4, 32'd0);
      saw = 1'b0;
      for (int i = 0; i < 6; i++) begin
         saw = saw | rvalid4;
         step();
      end
      chk("flight_no_rvalid", {31'd0, saw}, 32'd0);

      drive(1'b1, 4'h0, BASE + 32'd8, 32'h0);
      hit_cyc = -1;
      hit_dat = 32'h0;
      for (int i = 0; i < 6; i++) begin
         step();
         drive(1'b0, 4'h0, BASE, 32'h0);
         if (rvalid4 && hit_cyc < 0) begin
            hit_cyc = i;
            hit_dat = rdata4;
         end
      end
      chk("after_reset_lat", hit_cyc, 32'd3);
      chk("after_reset_data", hit_dat, 32'h55adbeef);
      chk("after_reset_rd_count", rdc4, 32'd1);

      // Out-of-range write on the latency-4 instance: err exactly 4 edges later, no rvalid.
      drive(1'b1, 4'hf, BASE + 32'd16384, 32'hffffffff);
      err_cyc = -1;
      saw = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         drive(1'b0, 4'h0, BASE, 32'h0);
         saw = saw | rvalid4;
         if (err4 && err_cyc < 0) err_cyc = i;
      end
      chk("oor_err_lat4", err_cyc, 32'd3);
      chk("oor_no_rvalid4", {31'd0, saw}, 32'd0);
      chk("oor_wr_count4", wrc4, 32'd0);

      // Streaming on the latency-3 instance.
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 4'hf, BASE + 32'(4 * k), 32'ha000_0000 + 32'(k));
         step();
      end
      drive(1'b0, 4'h0, BASE, 32'h0);
      for (int i = 0; i < 4; i++) step();
      for (int t = 0; t < 12; t++) begin
         if (t < 8) drive(1'b1, 4'h0, BASE + 32'(4 * t), 32'h0);
         else       drive(1'b0, 4'h0, BASE, 32'h0);
         step();
         chk($sformatf("stream_rvalid_t%0d", t), {31'd0, rvalid3}, (t >= 2 && t < 10) ? 32'd1 : 32'd0);
         if (t >= 2 && t < 10)
            chk($sformatf("stream_rdata_t%0d", t), rdata3, 32'ha000_0000 + 32'(t - 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
